// File: rtl/knap_search_ctrl.sv
// Exhaustive knapsack subset search: walks every item subset one per clock,
// evaluates value/weight/volume sums combinationally, and keeps the best
// feasible subset plus a count of feasible subsets.
module knap_search_ctrl #(
    parameter int unsigned N_ITEMS = 7,
    parameter int unsigned W       = 8,
    parameter int unsigned SW      = W + $clog2(N_ITEMS)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 abort,
    input  logic [N_ITEMS*W-1:0] item_value,
    input  logic [N_ITEMS*W-1:0] item_weight,
    input  logic [N_ITEMS*W-1:0] item_volume,
    input  logic [W-1:0]         min_value,
    input  logic [W-1:0]         max_weight,
    input  logic [W-1:0]         max_volume,
    output logic                 busy,
    output logic                 done,
    output logic                 found,
    output logic [N_ITEMS-1:0]   best_mask,
    output logic [SW-1:0]        best_value,
    output logic [N_ITEMS:0]     feasible_count
);

    typedef enum logic [1:0] {StIdle, StSearch, StDone} state_e;

    localparam logic [N_ITEMS-1:0] MaskOne  = N_ITEMS'(1);
    localparam logic [N_ITEMS:0]   CountOne = (N_ITEMS + 1)'(1);

    state_e state_q, state_d;

    logic [N_ITEMS-1:0]   mask_q;
    logic [N_ITEMS*W-1:0] value_q, weight_q, volume_q;
    logic [W-1:0]         min_value_q, max_weight_q, max_volume_q;

    logic [SW-1:0] value_sum, weight_sum, volume_sum;
    logic          feasible, better, last_mask;
    logic          load, step;

    // Multi-constraint evaluator for the current mask; sums are wide enough
    // that they never wrap.
    always_comb begin
        value_sum  = '0;
        weight_sum = '0;
        volume_sum = '0;
        for (int i = 0; i < int'(N_ITEMS); i++) begin
            if (mask_q[i]) begin
                value_sum  = value_sum  + SW'(value_q[i*W +: W]);
                weight_sum = weight_sum + SW'(weight_q[i*W +: W]);
                volume_sum = volume_sum + SW'(volume_q[i*W +: W]);
            end
        end
        feasible  = (value_sum >= SW'(min_value_q)) &&
                    (weight_sum <= SW'(max_weight_q)) &&
                    (volume_sum <= SW'(max_volume_q));
        // Strict compare so ties keep the lower, earlier mask.
        better    = !found || (value_sum > best_value);
        last_mask = &mask_q;
    end

    // Next-state decode: start wins in idle, abort wins in search.
    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        step    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StSearch;
                    load    = 1'b1;
                end
            end
            StSearch: begin
                if (abort) begin
                    state_d = StIdle;
                end else begin
                    step = 1'b1;
                    if (last_mask) begin
                        state_d = StDone;
                    end
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    assign busy = (state_q == StSearch);
    assign done = (state_q == StDone);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Operand latch on start, then per-mask result tracking during search.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mask_q         <= '0;
            value_q        <= '0;
            weight_q       <= '0;
            volume_q       <= '0;
            min_value_q    <= '0;
            max_weight_q   <= '0;
            max_volume_q   <= '0;
            found          <= 1'b0;
            best_mask      <= '0;
            best_value     <= '0;
            feasible_count <= '0;
        end else if (load) begin
            mask_q         <= '0;
            value_q        <= item_value;
            weight_q       <= item_weight;
            volume_q       <= item_volume;
            min_value_q    <= min_value;
            max_weight_q   <= max_weight;
            max_volume_q   <= max_volume;
            found          <= 1'b0;
            best_mask      <= '0;
            best_value     <= '0;
            feasible_count <= '0;
        end else if (step) begin
            mask_q <= mask_q + MaskOne;
            if (feasible) begin
                feasible_count <= feasible_count + CountOne;
                if (better) begin
                    found      <= 1'b1;
                    best_mask  <= mask_q;
                    best_value <= value_sum;
                end
            end
        end
    end

endmodule

// File: tb/tb_knap_search_ctrl.sv
// Self-checking bench for knap_search_ctrl: directed table cases, control
// corner cases, and randomized searches against a brute-force model.
module tb_knap_search_ctrl;

    localparam int N  = 7;
    localparam int W  = 8;
    localparam int SW = W + $clog2(N);

    logic             clk = 1'b0;
    logic             rst, start, abort;
    logic [N*W-1:0]   item_value, item_weight, item_volume;
    logic [W-1:0]     min_value, max_weight, max_volume;
    logic             busy, done, found;
    logic [N-1:0]     best_mask;
    logic [SW-1:0]    best_value;
    logic [N:0]       feasible_count;

    int errors   = 0;
    int checks   = 0;
    int done_cnt = 0;

    typedef struct {
        logic [N*W-1:0] v, wt, vo;
        logic [W-1:0]   mn, mw, mv;
        logic           f;
        logic [N-1:0]   m;
        int             bv;
        int             cnt;
    } vec_t;

    vec_t tbl[4];

    knap_search_ctrl #(.N_ITEMS(N), .W(W)) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .abort          (abort),
        .item_value     (item_value),
        .item_weight    (item_weight),
        .item_volume    (item_volume),
        .min_value      (min_value),
        .max_weight     (max_weight),
        .max_volume     (max_volume),
        .busy           (busy),
        .done           (done),
        .found          (found),
        .best_mask      (best_mask),
        .best_value     (best_value),
        .feasible_count (feasible_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (done === 1'b1) done_cnt <= done_cnt + 1;

    function automatic logic [N*W-1:0] pack(input int a0, input int a1, input int a2,
                                            input int a3, input int a4, input int a5,
                                            input int a6);
        return {W'(a6), W'(a5), W'(a4), W'(a3), W'(a2), W'(a1), W'(a0)};
    endfunction

    // Brute force over all subsets with plain integer arithmetic.
    function automatic void model(input logic [N*W-1:0] v, input logic [N*W-1:0] wt,
                                  input logic [N*W-1:0] vo, input logic [W-1:0] mn,
                                  input logic [W-1:0] mw, input logic [W-1:0] mv,
                                  output logic f, output logic [N-1:0] bm,
                                  output int bv, output int cnt);
        int sv, sw, so;
        f = 1'b0; bm = '0; bv = 0; cnt = 0;
        for (int m = 0; m < (1 << N); m++) begin
            sv = 0; sw = 0; so = 0;
            for (int i = 0; i < N; i++) begin
                if (((m >> i) & 1) == 1) begin
                    sv += int'(v[i*W +: W]);
                    sw += int'(wt[i*W +: W]);
                    so += int'(vo[i*W +: W]);
                end
            end
            if (sv >= int'(mn) && sw <= int'(mw) && so <= int'(mv)) begin
                cnt++;
                if (!f || sv > bv) begin
                    f  = 1'b1;
                    bm = m[N-1:0];
                    bv = sv;
                end
            end
        end
    endfunction

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_results(input string tag, input logic f, input logic [N-1:0] m,
                                 input int bv, input int cnt);
        check({tag, " found"}, longint'(found), longint'(f));
        check({tag, " best_mask"}, longint'(best_mask), longint'(m));
        check({tag, " best_value"}, longint'(best_value), longint'(bv));
        check({tag, " feasible_count"}, longint'(feasible_count), longint'(cnt));
    endtask

    task automatic set_inputs(input vec_t t);
        item_value  = t.v;
        item_weight = t.wt;
        item_volume = t.vo;
        min_value   = t.mn;
        max_weight  = t.mw;
        max_volume  = t.mv;
    endtask

    // Called #1 after an edge. Pulses start, then waits (bounded) for done.
    // With perturb set, inputs and start are scrambled every search cycle.
    task automatic run_search(input bit perturb, output int cycles);
        start = 1'b1;
        @(posedge clk); #1;
        start  = 1'b0;
        cycles = 1;
        while (done !== 1'b1 && cycles < 400) begin
            @(posedge clk); #1;
            cycles++;
            if (perturb && done !== 1'b1) begin
                item_value  = 56'({$urandom(), $urandom()});
                item_weight = 56'({$urandom(), $urandom()});
                item_volume = 56'({$urandom(), $urandom()});
                min_value   = 8'($urandom());
                max_weight  = 8'($urandom());
                max_volume  = 8'($urandom());
                start       = 1'($urandom_range(0, 1));
            end
        end
        start = 1'b0;
    endtask

    // Runs a search and checks latency, pulse shape and final results.
    task automatic full_check(input string tag, input bit perturb, input logic f,
                              input logic [N-1:0] m, input int bv, input int cnt);
        int cyc;
        run_search(perturb, cyc);
        check({tag, " latency"}, cyc, 129);
        check({tag, " busy_at_done"}, longint'(busy), 0);
        check_results(tag, f, m, bv, cnt);
        @(posedge clk); #1;
        check({tag, " done_one_cycle"}, longint'(done), 0);
        check({tag, " hold_value"}, longint'(best_value), longint'(bv));
    endtask

    initial begin
        vec_t         t;
        logic         ef;
        logic [N-1:0] em;
        int           ev, ec, dc;

        tbl[0] = '{pack(4, 8, 0, 20, 10, 12, 18), pack(28, 8, 27, 18, 27, 28, 6),
                   pack(27, 27, 4, 4, 0, 24, 4), 8'd58, 8'd60, 8'd60,
                   1'b1, 7'h6A, 58, 1};
        tbl[1] = '{pack(4, 8, 0, 20, 10, 12, 18), pack(28, 8, 27, 18, 27, 28, 6),
                   pack(27, 27, 4, 4, 0, 24, 4), 8'd59, 8'd60, 8'd60,
                   1'b0, 7'h00, 0, 0};
        tbl[2] = '{pack(1, 2, 3, 4, 5, 6, 7), pack(0, 0, 0, 0, 0, 0, 0),
                   pack(0, 0, 0, 0, 0, 0, 0), 8'd0, 8'd0, 8'd0,
                   1'b1, 7'h7F, 28, 128};
        tbl[3] = '{pack(5, 5, 5, 5, 5, 5, 5), pack(10, 10, 10, 10, 10, 10, 10),
                   pack(0, 0, 0, 0, 0, 0, 0), 8'd5, 8'd10, 8'd0,
                   1'b1, 7'h01, 5, 7};

        rst = 1'b1; start = 1'b0; abort = 1'b0;
        set_inputs(tbl[0]);
        #12;
        check("reset busy", longint'(busy), 0);
        check("reset done", longint'(done), 0);
        check_results("reset", 1'b0, '0, 0, 0);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;

        // Directed table cases.
        for (int k = 0; k < 4; k++) begin
            set_inputs(tbl[k]);
            full_check($sformatf("table%0d", k), 1'b0, tbl[k].f, tbl[k].m, tbl[k].bv,
                       tbl[k].cnt);
        end

        // Start together with abort in idle: start wins; held abort then
        // ends the search on the next edge with no done pulse.
        set_inputs(tbl[2]);
        dc = done_cnt;
        start = 1'b1; abort = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("start_wins busy", longint'(busy), 1);
        @(posedge clk); #1;
        abort = 1'b0;
        check("abort_wins busy", longint'(busy), 0);

        // Abort on search cycle 20, then a fresh baseline search.
        set_inputs(tbl[0]);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (19) begin @(posedge clk); #1; end
        check("pre_abort busy", longint'(busy), 1);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        check("abort busy", longint'(busy), 0);
        repeat (5) begin @(posedge clk); #1; end
        check("abort no_done", done_cnt, dc);
        check("abort stays_idle", longint'(busy), 0);
        full_check("after_abort", 1'b0, tbl[0].f, tbl[0].m, tbl[0].bv, tbl[0].cnt);

        // Asynchronous reset between edges mid-search.
        set_inputs(tbl[2]);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (50) begin @(posedge clk); #1; end
        #2 rst = 1'b1;
        #1;
        check("midrst busy", longint'(busy), 0);
        check("midrst done", longint'(done), 0);
        check_results("midrst", 1'b0, '0, 0, 0);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        set_inputs(tbl[0]);
        full_check("after_rst", 1'b0, tbl[0].f, tbl[0].m, tbl[0].bv, tbl[0].cnt);

        // Randomized searches; inputs and start scrambled during search.
        for (int r = 0; r < 24; r++) begin
            for (int i = 0; i < N; i++) begin
                t.v[i*W +: W]  = (r % 3 == 0) ? 8'($urandom()) : 8'($urandom_range(0, 40));
                t.wt[i*W +: W] = 8'($urandom_range(0, 50));
                t.vo[i*W +: W] = 8'($urandom_range(0, 50));
            end
            t.mn = (r % 3 == 0) ? 8'd0 : 8'($urandom_range(0, 120));
            t.mw = 8'($urandom_range(20, 255));
            t.mv = 8'($urandom_range(20, 255));
            model(t.v, t.wt, t.vo, t.mn, t.mw, t.mv, ef, em, ev, ec);
            set_inputs(t);
            full_check($sformatf("rand%0d", r), 1'b1, ef, em, ev, ec);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
